// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: shares one RAM port between client 0 (CPU) and client 1 (VGA) with a watchdog
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   cN_req/we/addr/wdata           client N request (held until cN_ack), direction, address, write data
//   cN_ack/err/rdata               one-cycle completion pulse, timeout flag, read data (0 for writes)
//   ram_req/we/addr/wdata          RAM request held for the whole transaction, with stable command
//   ram_done/rdata                 RAM completion and read data
//   busy, grant                    transaction in flight, owning client index
module ram_bus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 255,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c0_req,
    input  logic              c0_we,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [DATA_W-1:0] c0_wdata,
    output logic              c0_ack,
    output logic              c0_err,
    output logic [DATA_W-1:0] c0_rdata,
    input  logic              c1_req,
    input  logic              c1_we,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic              c1_ack,
    output logic              c1_err,
    output logic [DATA_W-1:0] c1_rdata,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic              ram_done,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              grant
);
    localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_n;
    logic last, last_n, win;
    logic [TW-1:0] timer, timer_n;
    logic req_n, we_n, busy_n, grant_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] wdata_n;
    logic [1:0] ack, ack_n, err, err_n;
    logic [DATA_W-1:0] rdata [2];
    logic [DATA_W-1:0] rdata_n [2];
    // round-robin only matters on contention: the client that did not win last time goes first
    assign win = FIXED_PRIO != 0 ? !c0_req : (c0_req && c1_req) ? !last : c1_req;
    assign c0_ack = ack[0];
    assign c1_ack = ack[1];
    assign c0_err = err[0];
    assign c1_err = err[1];
    assign c0_rdata = rdata[0];
    assign c1_rdata = rdata[1];
    always_comb begin
        state_n = state;
        last_n = last;
        timer_n = timer;
        req_n = ram_req;
        we_n = ram_we;
        addr_n = ram_addr;
        wdata_n = ram_wdata;
        busy_n = busy;
        grant_n = grant;
        ack_n = ack;
        err_n = err;
        rdata_n = rdata;
        case (state)
            IDLE: if (c0_req || c1_req) begin
                state_n = WAIT;
                req_n = 1'b1;
                busy_n = 1'b1;
                grant_n = win;
                last_n = win;
                timer_n = '0;
                we_n = win ? c1_we : c0_we;
                addr_n = win ? c1_addr : c0_addr;
                wdata_n = win ? c1_wdata : c0_wdata;
            end
            WAIT: begin
                timer_n = timer + 1'b1;
                // done wins over a coincident timeout; exiting at TIMEOUT-1 keeps the timer from wrapping
                if (ram_done || (TIMEOUT != 0 && timer == T_LAST)) begin
                    state_n = RESP;
                    req_n = 1'b0;
                    ack_n[grant] = 1'b1;
                    err_n[grant] = !ram_done;
                    rdata_n[grant] = (ram_done && !ram_we) ? ram_rdata : '0;
                end
            end
            default: begin
                state_n = IDLE;
                busy_n = 1'b0;
                ack_n = '0;
                err_n = '0;
            end
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            last <= 1'b1;
            timer <= '0;
            ram_req <= 1'b0;
            ram_we <= 1'b0;
            ram_addr <= '0;
            ram_wdata <= '0;
            busy <= 1'b0;
            grant <= 1'b0;
            ack <= '0;
            err <= '0;
            rdata[0] <= '0;
            rdata[1] <= '0;
        end else begin
            state <= state_n;
            last <= last_n;
            timer <= timer_n;
            ram_req <= req_n;
            ram_we <= we_n;
            ram_addr <= addr_n;
            ram_wdata <= wdata_n;
            busy <= busy_n;
            grant <= grant_n;
            ack <= ack_n;
            err <= err_n;
            rdata[0] <= rdata_n[0];
            rdata[1] <= rdata_n[1];
        end
    end
endmodule

// File: tb/tb_ram_bus_arbiter.sv
// tb_ram_bus_arbiter: checks a round-robin instance (0) and a fixed-priority instance (1), both TIMEOUT=8
module tb_ram_bus_arbiter;
    localparam int TO = 8;
    logic clk = 0;
    logic rst = 0;
    always #5 clk = ~clk;
    logic c0_req [2], c1_req [2], c0_we [2], c1_we [2], ram_done [2];
    logic [31:0] c0_addr [2], c1_addr [2], c0_wdata [2], c1_wdata [2], ram_rdata [2];
    logic c0_ack [2], c1_ack [2], c0_err [2], c1_err [2], ram_req [2], ram_we [2], busy [2], grant [2];
    logic [31:0] c0_rdata [2], c1_rdata [2], ram_addr [2], ram_wdata [2];
    int rem0 [2], rem1 [2], lat [2], rcnt [2];
    logic [31:0] rdval [2];
    int vectors = 0, miscompares = 0;

    ram_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .FIXED_PRIO(0)) u0 (
        .clk(clk), .rst(rst),
        .c0_req(c0_req[0]), .c0_we(c0_we[0]), .c0_addr(c0_addr[0]), .c0_wdata(c0_wdata[0]),
        .c0_ack(c0_ack[0]), .c0_err(c0_err[0]), .c0_rdata(c0_rdata[0]),
        .c1_req(c1_req[0]), .c1_we(c1_we[0]), .c1_addr(c1_addr[0]), .c1_wdata(c1_wdata[0]),
        .c1_ack(c1_ack[0]), .c1_err(c1_err[0]), .c1_rdata(c1_rdata[0]),
        .ram_req(ram_req[0]), .ram_we(ram_we[0]), .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]),
        .ram_done(ram_done[0]), .ram_rdata(ram_rdata[0]), .busy(busy[0]), .grant(grant[0]));

    ram_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .FIXED_PRIO(1)) u1 (
        .clk(clk), .rst(rst),
        .c0_req(c0_req[1]), .c0_we(c0_we[1]), .c0_addr(c0_addr[1]), .c0_wdata(c0_wdata[1]),
        .c0_ack(c0_ack[1]), .c0_err(c0_err[1]), .c0_rdata(c0_rdata[1]),
        .c1_req(c1_req[1]), .c1_we(c1_we[1]), .c1_addr(c1_addr[1]), .c1_wdata(c1_wdata[1]),
        .c1_ack(c1_ack[1]), .c1_err(c1_err[1]), .c1_rdata(c1_rdata[1]),
        .ram_req(ram_req[1]), .ram_we(ram_we[1]), .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]),
        .ram_done(ram_done[1]), .ram_rdata(ram_rdata[1]), .busy(busy[1]), .grant(grant[1]));

    // transaction-level model: m_on = command on the bus, m_age = cycles the bus has waited,
    // m_resp = completion being reported this cycle
    logic m_on [2], m_we [2], m_busy [2], m_grant [2], m_last [2], m_resp [2];
    logic [31:0] m_addr [2], m_wdata [2];
    logic [1:0] m_ack [2], m_err [2];
    logic [31:0] m_rd [2][2];
    int m_age [2];

    function automatic logic pick(input int i);
        return (c0_req[i] && c1_req[i]) ? (i == 1 ? 1'b0 : !m_last[i]) : !c0_req[i];
    endfunction

    always @(posedge clk or posedge rst)
        for (int i = 0; i < 2; i++)
            if (rst) begin
                m_on[i] <= 0; m_we[i] <= 0; m_busy[i] <= 0; m_grant[i] <= 0; m_last[i] <= 1; m_resp[i] <= 0;
                m_addr[i] <= 0; m_wdata[i] <= 0; m_ack[i] <= 0; m_err[i] <= 0; m_age[i] <= 0;
                m_rd[i][0] <= 0; m_rd[i][1] <= 0;
            end else if (m_resp[i]) begin
                m_resp[i] <= 0; m_ack[i] <= 0; m_err[i] <= 0; m_busy[i] <= 0;
            end else if (m_on[i]) begin
                m_age[i] <= m_age[i] + 1;
                if (ram_done[i] || m_age[i] + 1 == TO) begin
                    m_on[i] <= 0;
                    m_resp[i] <= 1;
                    m_ack[i] <= 2'b01 << m_grant[i];
                    m_err[i] <= ram_done[i] ? 2'b00 : 2'b01 << m_grant[i];
                    m_rd[i][m_grant[i]] <= (ram_done[i] && !m_we[i]) ? ram_rdata[i] : 32'h0;
                end
            end else if (c0_req[i] || c1_req[i]) begin
                m_on[i] <= 1; m_busy[i] <= 1; m_age[i] <= 0;
                m_grant[i] <= pick(i); m_last[i] <= pick(i);
                m_we[i] <= pick(i) ? c1_we[i] : c0_we[i];
                m_addr[i] <= pick(i) ? c1_addr[i] : c0_addr[i];
                m_wdata[i] <= pick(i) ? c1_wdata[i] : c0_wdata[i];
            end

    function automatic logic [135:0] got_vec(input int i);
        return {ram_req[i], busy[i], c1_ack[i], c0_ack[i], c1_err[i], c0_err[i], c1_rdata[i], c0_rdata[i],
                m_on[i] ? {ram_we[i], ram_addr[i], ram_wdata[i]} : 65'b0, m_busy[i] ? grant[i] : 1'b0};
    endfunction

    function automatic logic [135:0] want_vec(input int i);
        return {m_on[i], m_busy[i], m_ack[i][1], m_ack[i][0], m_err[i][1], m_err[i][0], m_rd[i][1], m_rd[i][0],
                m_on[i] ? {m_we[i], m_addr[i], m_wdata[i]} : 65'b0, m_busy[i] ? m_grant[i] : 1'b0};
    endfunction

    always @(negedge clk)
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (got_vec(i) !== want_vec(i)) begin
                miscompares++;
                $display("FAIL cycle_inst%0d t=%0t got %h want %h", i, $time, got_vec(i), want_vec(i));
            end
        end

    // clients drop req when they see their last ack; RAM answers lat cycles into ram_req (0 = never)
    initial forever begin
        @(posedge clk);
        #2;
        for (int i = 0; i < 2; i++) begin
            if (c0_ack[i] && rem0[i] > 0) rem0[i]--;
            if (c1_ack[i] && rem1[i] > 0) rem1[i]--;
            c0_req[i] = rem0[i] > 0;
            c1_req[i] = rem1[i] > 0;
            if (ram_req[i] && !ram_done[i]) begin
                rcnt[i]++;
                ram_done[i] = lat[i] != 0 && rcnt[i] == lat[i];
            end else begin
                rcnt[i] = 0;
                ram_done[i] = 0;
            end
            ram_rdata[i] = rdval[i];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic go_ack(input int i, output int n, output int hi);
        n = 0;
        hi = 0;
        do begin
            tick();
            n++;
            if (ram_req[i]) hi++;
        end while (!(c0_ack[i] || c1_ack[i]) && n < 40);
        check("ack_seen", 64'(c0_ack[i] | c1_ack[i]), 1);
    endtask

    initial begin
        int n, hi;
        for (int i = 0; i < 2; i++) begin
            c0_req[i] = 0; c1_req[i] = 0; c0_we[i] = 0; c1_we[i] = 0; ram_done[i] = 0;
            c0_addr[i] = 0; c1_addr[i] = 0; c0_wdata[i] = 0; c1_wdata[i] = 0; ram_rdata[i] = 0;
            rem0[i] = 0; rem1[i] = 0; lat[i] = 1; rcnt[i] = 0; rdval[i] = 0;
        end
        #1 rst = 1;
        repeat (3) tick();
        check("rst_ram_req", {ram_req[0], ram_req[1]}, 0);
        check("rst_busy", {busy[0], busy[1], grant[0], grant[1]}, 0);
        check("rst_ack_err", {c0_ack[0], c1_ack[0], c0_err[1], c1_err[1]}, 0);
        rst = 0;
        tick();
        // read with done in the fourth ram_req cycle
        c0_addr[0] = 32'h10; lat[0] = 4; rdval[0] = 32'hDEADBEEF; rem0[0] = 1;
        go_ack(0, n, hi);
        check("t1_latency", 64'(n), 5);
        check("t1_ram_req_cycles", 64'(hi), 4);
        check("t1_rdata", c0_rdata[0], 32'hDEADBEEF);
        check("t1_err", c0_err[0], 0);
        check("t1_busy_in_resp", busy[0], 1);
        tick();
        check("t1_ack_pulse", {c0_ack[0], busy[0]}, 0);
        // write from client 1 completing in the first ram_req cycle
        c1_we[0] = 1; c1_addr[0] = 32'h4; c1_wdata[0] = 32'h55; lat[0] = 1; rdval[0] = 32'hFFFF0000; rem1[0] = 1;
        tick();
        check("t6_ram_cmd", {ram_req[0], ram_we[0], grant[0]}, 3'b111);
        check("t6_ram_addr", ram_addr[0], 32'h4);
        check("t6_ram_wdata", ram_wdata[0], 32'h55);
        go_ack(0, n, hi);
        check("t6_latency", 64'(n + 1), 2);
        check("t6_c1_ack", c1_ack[0], 1);
        check("t6_c1_rdata", c1_rdata[0], 0);
        check("t6_c0_rdata_hold", c0_rdata[0], 32'hDEADBEEF);
        tick();
        // contention: round-robin alternates starting with client 0
        rdval[0] = 32'h12345678; c0_addr[0] = 32'h20; c1_addr[0] = 32'h24; rem0[0] = 2; rem1[0] = 2;
        for (int t = 0; t < 4; t++) begin
            go_ack(0, n, hi);
            check("t2_owner", c1_ack[0], 64'(t % 2));
            check("t2_ram_idle_in_resp", ram_req[0], 0);
        end
        check("t2_c0_rdata", c0_rdata[0], 32'h12345678);
        tick();
        // RAM never answers: watchdog fires after TO cycles, then a normal read
        lat[0] = 0; rdval[0] = 32'hCAFEF00D; c0_addr[0] = 32'h30; rem0[0] = 1;
        go_ack(0, n, hi);
        check("t4_latency", 64'(n), 9);
        check("t4_ram_req_cycles", 64'(hi), 8);
        check("t4_ack_err", {c0_ack[0], c0_err[0]}, 2'b11);
        check("t4_rdata_zero", c0_rdata[0], 0);
        tick();
        lat[0] = 2; rem0[0] = 1;
        go_ack(0, n, hi);
        check("t4_recover", {c0_ack[0], c0_err[0]}, 2'b10);
        check("t4_recover_rdata", c0_rdata[0], 32'hCAFEF00D);
        tick();
        // asynchronous reset in the middle of WAIT
        lat[0] = 0; rem0[0] = 1;
        tick();
        tick();
        check("t5_in_wait", ram_req[0], 1);
        rem0[0] = 0;
        rst = 1;
        #1;
        check("t5_async_clear", {ram_req[0], busy[0], c0_ack[0]}, 0);
        check("t5_rdata_clear", c0_rdata[0], 0);
        repeat (2) tick();
        rst = 0;
        tick();
        c0_we[0] = 0; c1_we[0] = 0; lat[0] = 1; rdval[0] = 32'hBEEF; rem0[0] = 1; rem1[0] = 1;
        go_ack(0, n, hi);
        check("t5_c0_first", {c0_ack[0], c1_ack[0]}, 2'b10);
        go_ack(0, n, hi);
        check("t5_c1_next", {c0_ack[0], c1_ack[0]}, 2'b01);
        tick();
        // fixed priority: client 1 waits until client 0 lets go
        lat[1] = 1; rdval[1] = 32'h77; rem0[1] = 3; rem1[1] = 1;
        for (int t = 0; t < 4; t++) begin
            go_ack(1, n, hi);
            check("t3_owner", c1_ack[1], 64'(t == 3));
        end
        check("t3_c1_rdata", c1_rdata[1], 32'h77);
        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
